// File: rtl/s_stream_feeder_pkg.sv
// Shared types and constants for the PEA border-PE stream feeder.
// Optional zero-latency bypass is enabled by defining S_STREAM_FEEDER_BYPASS_EN.
package s_stream_feeder_pkg;

    localparam int FEED_N_BITS     = 32;
    localparam int FEED_FIFO_DEPTH = 4;
    localparam int FEED_LEN_W      = 16;

    typedef enum logic [1:0] {
        FEED_IDLE   = 2'd0,
        FEED_STREAM = 2'd1,
        FEED_DRAIN  = 2'd2,
        FEED_DONE   = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/s_feed_fifo.sv
// Small synchronous FIFO with registered storage; head is read straight from storage.
module s_feed_fifo #(
    parameter int N_BITS     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [N_BITS-1:0] data,
    output logic [N_BITS-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [N_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W:0]    count_r;
    logic              do_push_s;
    logic              do_pop_s;

    assign full      = (count_r == (PTR_W+1)'(FIFO_DEPTH));
    assign empty     = (count_r == '0);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r];

    // Storage, pointers (wrap modulo depth) and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/s_stream_feeder.sv
// Streams a programmed number of words from an upstream ready/valid source into a PE operand slot.
// Define S_STREAM_FEEDER_BYPASS_EN for a combinational empty-FIFO bypass (zero latency).
module s_stream_feeder
    import s_stream_feeder_pkg::*;
#(
    parameter int N_BITS     = FEED_N_BITS,
    parameter int FIFO_DEPTH = FEED_FIFO_DEPTH,
    parameter int LEN_W      = FEED_LEN_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              mage_done_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [N_BITS-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              pea_ready_i,
    input  logic              pe_ready_i,
    output logic [N_BITS-1:0] op_o,
    output logic              op_valid_o,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o
);

    feeder_state_t     state_r;
    feeder_state_t     next_state_s;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  acc_cnt_r;
    logic [LEN_W-1:0]  iss_cnt_r;
    logic              done_r;

    logic              push_s;
    logic              pop_s;
    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [N_BITS-1:0] fifo_head_s;
    logic              active_s;
    logic              last_hit_s;
    logic              acc_reached_s;

    assign active_s      = (state_r == FEED_STREAM) || (state_r == FEED_DRAIN);
    assign in_ready_o    = (state_r == FEED_STREAM) && !fifo_full_s && (acc_cnt_r < len_r);
    assign push_s        = in_valid_i && in_ready_o;
    assign pop_s         = op_valid_o && pe_ready_i && pea_ready_i;
    assign last_hit_s    = (iss_cnt_r == (len_r - LEN_W'(1)));
    assign last_o        = op_valid_o && last_hit_s;
    assign acc_reached_s = (acc_cnt_r == len_r) || (push_s && ((acc_cnt_r + LEN_W'(1)) == len_r));
    assign busy_o        = active_s;
    assign done_o        = done_r;

`ifdef S_STREAM_FEEDER_BYPASS_EN
    logic bypass_s;
    // An empty FIFO lets the incoming word straight through; a same-cycle pop skips the write.
    assign bypass_s    = fifo_empty_s && push_s;
    assign op_valid_o  = (!fifo_empty_s && active_s) || bypass_s;
    assign op_o        = bypass_s ? in_data_i : fifo_head_s;
    assign fifo_push_s = push_s && !(bypass_s && pop_s);
    assign fifo_pop_s  = pop_s && !bypass_s;
`else
    assign op_valid_o  = !fifo_empty_s && active_s;
    assign op_o        = fifo_head_s;
    assign fifo_push_s = push_s;
    assign fifo_pop_s  = pop_s;
`endif

    s_feed_fifo #(
        .N_BITS     (N_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .flush (mage_done_i),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .data  (in_data_i),
        .head  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Next-state logic; flush overrides everything including start.
    always_comb begin
        next_state_s = state_r;
        if (mage_done_i) begin
            next_state_s = FEED_IDLE;
        end else begin
            case (state_r)
                FEED_IDLE: begin
                    if (start_i) begin
                        next_state_s = (len_i != '0) ? FEED_STREAM : FEED_DONE;
                    end else begin
                        next_state_s = FEED_IDLE;
                    end
                end
                FEED_STREAM: begin
                    if (pop_s && last_hit_s) begin
                        next_state_s = FEED_DONE;
                    end else if (acc_reached_s) begin
                        next_state_s = FEED_DRAIN;
                    end else begin
                        next_state_s = FEED_STREAM;
                    end
                end
                FEED_DRAIN: begin
                    if (pop_s && last_hit_s) begin
                        next_state_s = FEED_DONE;
                    end else begin
                        next_state_s = FEED_DRAIN;
                    end
                end
                FEED_DONE: next_state_s = FEED_IDLE;
                default:   next_state_s = FEED_IDLE;
            endcase
        end
    end

    // State, run length, push/pop counters and the registered completion pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r   <= FEED_IDLE;
            len_r     <= '0;
            acc_cnt_r <= '0;
            iss_cnt_r <= '0;
            done_r    <= 1'b0;
        end else if (mage_done_i) begin
            state_r   <= FEED_IDLE;
            acc_cnt_r <= '0;
            iss_cnt_r <= '0;
            done_r    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            done_r  <= (state_r == FEED_DONE);
            if ((state_r == FEED_IDLE) && start_i) begin
                len_r     <= len_i;
                acc_cnt_r <= '0;
                iss_cnt_r <= '0;
            end else begin
                if (push_s) begin
                    acc_cnt_r <= acc_cnt_r + LEN_W'(1);
                end
                if (pop_s) begin
                    iss_cnt_r <= iss_cnt_r + LEN_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_s_stream_feeder.sv
// Directed self-checking bench for s_stream_feeder (default build, bypass disabled).
module tb_s_stream_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mage_done = 1'b0;
    logic        start = 1'b0;
    logic [15:0] len = 16'd0;
    logic [31:0] in_data = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        pea_ready = 1'b1;
    logic        pe_ready = 1'b1;
    logic [31:0] op;
    logic        op_valid;
    logic        last;
    logic        busy;
    logic        done;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] word_base = 32'd0;

    always #5 clk = ~clk;

    s_stream_feeder dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .mage_done_i (mage_done),
        .start_i     (start),
        .len_i       (len),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .pea_ready_i (pea_ready),
        .pe_ready_i  (pe_ready),
        .op_o        (op),
        .op_valid_o  (op_valid),
        .last_o      (last),
        .busy_o      (busy),
        .done_o      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input int k);
        return word_base + 32'h11 * 32'(k + 1);
    endfunction

    task automatic do_start(input int l);
        start = 1'b1;
        len   = 16'(l);
        tick();
        start = 1'b0;
    endtask

    // mode 0: free flow, 1: PE backpressure first 10 cycles, 2: alternating global stall, 3: random
    task automatic run(input int n, input int mode);
        int          cyc, pushed, popped, n_done, last_pop, done_cyc, after;
        logic        held, pushing, popping;
        logic [31:0] held_op;
        cyc = 0; pushed = 0; popped = 0; n_done = 0;
        last_pop = -1; done_cyc = -1; after = 0; held = 1'b0; held_op = 32'd0;
        do_start(n);
        while (after < 4 && cyc < 400) begin
            pea_ready = 1'b1;
            pe_ready  = 1'b1;
            in_valid  = 1'b1;
            case (mode)
                1: pe_ready = (cyc >= 10);
                2: begin
                    pea_ready = (cyc % 2 == 0);
                    start     = (cyc == 3);
                    len       = 16'd1;
                end
                3: begin
                    in_valid = ($urandom_range(0, 1) == 1);
                    pe_ready = ($urandom_range(0, 3) != 0);
                end
                default: ;
            endcase
            in_data = word(pushed);
            pushing = in_valid && in_ready;
            popping = op_valid && pe_ready && pea_ready;
            if (held) begin
                check("hold_valid", {31'd0, op_valid}, 32'd1);
                check("hold_data", op, held_op);
            end
            if (popping) begin
                check("data", op, word(popped));
                check("last", {31'd0, last}, {31'd0, popped == n - 1});
                if (mode == 0) check("pop_cycle", cyc, popped + 1);
                popped++;
                last_pop = cyc;
            end
            held    = op_valid && !popping;
            held_op = op;
            if (mode == 1 && cyc == 9) begin
                check("bp_in_ready", {31'd0, in_ready}, 32'd0);
                check("bp_head", op, word(0));
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (pushing) pushed++;
            if (done_cyc >= 0) after++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        len       = 16'd0;
        pe_ready  = 1'b1;
        pea_ready = 1'b1;
        check("run_timeout", {31'd0, done_cyc >= 0}, 32'd1);
        check("done_count", n_done, 1);
        check("words_popped", popped, n);
        check("done_latency", done_cyc, last_pop + 2);
        check("busy_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_op_valid", {31'd0, op_valid}, 32'd0);
        check("rst_op", op, 32'd0);
        check("rst_last", {31'd0, last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic run: 0x11..0x44
        run(4, 0);

        // Backpressure: 0x11..0x88 held behind a stalled PE
        run(8, 1);

        // Global stall with a start pulse that must be ignored mid-run
        word_base = 32'h1000;
        run(6, 2);

        // Zero length
        do_start(0);
        check("zl_done0", {31'd0, done}, 32'd0);
        check("zl_in_ready", {31'd0, in_ready}, 32'd0);
        check("zl_op_valid", {31'd0, op_valid}, 32'd0);
        tick();
        check("zl_done1", {31'd0, done}, 32'd1);
        check("zl_busy", {31'd0, busy}, 32'd0);
        check("zl_op_valid2", {31'd0, op_valid}, 32'd0);
        tick();
        check("zl_done2", {31'd0, done}, 32'd0);

        // Flush mid-run after 3 pushes and 1 pop
        word_base = 32'h100;
        do_start(6);
        in_valid = 1'b1;
        in_data  = word(0);
        tick();
        in_data = word(1);
        check("fl_valid", {31'd0, op_valid}, 32'd1);
        check("fl_head0", op, word(0));
        tick();
        in_data  = word(2);
        pe_ready = 1'b0;
        tick();
        in_valid  = 1'b0;
        mage_done = 1'b1;
        check("fl_head1", op, word(1));
        tick();
        mage_done = 1'b0;
        pe_ready  = 1'b1;
        check("fl_op_valid", {31'd0, op_valid}, 32'd0);
        check("fl_in_ready", {31'd0, in_ready}, 32'd0);
        check("fl_done", {31'd0, done}, 32'd0);
        check("fl_busy", {31'd0, busy}, 32'd0);
        tick();
        check("fl_done_late", {31'd0, done}, 32'd0);
        tick();
        word_base = 32'h200;
        run(2, 0);

        // Wrap with random valid/ready
        word_base = 32'h5000;
        run(20, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
